// File: rtl/speed_pkg.sv
// Shared types and width helpers for the multi-channel speed estimator.
package speed_pkg;

    typedef enum logic [1:0] {StIdle, StDiv, StDone} div_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    function automatic int unsigned num_width(input int unsigned dist_w,
                                              input int unsigned shift);
        return dist_w + shift;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/speed_div_seq.sv
// Start/done restoring divider, one quotient bit per cycle, quotient saturated to SPD_W.
module speed_div_seq
    import speed_pkg::*;
#(
    parameter int unsigned NUM_W  = 16,
    parameter int unsigned TIME_W = 16,
    parameter int unsigned SPD_W  = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [NUM_W-1:0]  numer_i,
    input  logic [TIME_W-1:0] denom_i,
    output logic              done_o,
    output logic              busy_o,
    output logic [SPD_W-1:0]  quot_o
);
    localparam int unsigned CNT_W = clog2(NUM_W + 1);

    div_state_e        state_q;
    logic [NUM_W-1:0]  nq_q;  // numerator bits shift out at the top, quotient bits in at the bottom
    logic [TIME_W-1:0] rem_q;
    logic [TIME_W-1:0] den_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [TIME_W:0] rem_sh;
    logic [TIME_W:0] rem_sub;
    logic            q_bit;

    always_comb begin
        rem_sh  = {rem_q, nq_q[NUM_W-1]};
        rem_sub = rem_sh - {1'b0, den_q};
        q_bit   = (rem_sh >= {1'b0, den_q});
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            nq_q    <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        nq_q    <= numer_i;
                        den_q   <= denom_i;
                        rem_q   <= '0;
                        cnt_q   <= CNT_W'(NUM_W);
                        state_q <= StDiv;
                    end
                end
                StDiv: begin
                    nq_q  <= {nq_q[NUM_W-2:0], q_bit};
                    rem_q <= q_bit ? rem_sub[TIME_W-1:0] : rem_sh[TIME_W-1:0];
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= StDone;
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign done_o = (state_q == StDone);
    assign busy_o = (state_q != StIdle);

    if (NUM_W > SPD_W) begin : g_sat
        assign quot_o = (|nq_q[NUM_W-1:SPD_W]) ? {SPD_W{1'b1}} : nq_q[SPD_W-1:0];
    end else begin : g_ext
        assign quot_o = SPD_W'(nq_q);
    end

endmodule

// File: rtl/speed_estimator.sv
// Multi-channel speed estimator sharing one sequential divider under round-robin arbitration.
// Define SPEED_AVG_EN to average the last AVG_DEPTH results per channel (one extra cycle).
module speed_estimator
    import speed_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DIST_W      = 10,
    parameter int unsigned SPD_W       = 10,
    parameter int unsigned TIME_W      = 16,
    parameter int unsigned SCALE_SHIFT = 6,
    parameter int unsigned AVG_DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        sample_valid,
    input  logic [CHANNELS*DIST_W-1:0] distance,
    output logic [CHANNELS*SPD_W-1:0]  speed,
    output logic [CHANNELS-1:0]        speed_valid,
    output logic [CHANNELS-1:0]        approaching,
    output logic [CHANNELS-1:0]        overrun,
    output logic                       busy
);
    localparam int unsigned NUM_W = num_width(DIST_W, SCALE_SHIFT);
    localparam int unsigned CH_W  = idx_width(CHANNELS);

    if (CHANNELS < 1 || CHANNELS > 8 || AVG_DEPTH < 2 || (AVG_DEPTH & (AVG_DEPTH - 1)) != 0)
    begin : g_param_check
        $error("speed_estimator: CHANNELS must be 1..8, AVG_DEPTH a power of 2 >= 2");
    end

    logic [DIST_W-1:0] prev_q   [CHANNELS];
    logic [DIST_W-1:0] jdelta_q [CHANNELS];
    logic [TIME_W-1:0] jintv_q  [CHANNELS];
    logic [TIME_W-1:0] intv_q   [CHANNELS];
    logic [CHANNELS-1:0] primed_q, pending_q, jappr_q, overrun_q;
    logic [CH_W-1:0]     rr_q, grant_q, gnt_idx;
    logic                gnt_any, gnt_appr_q, div_start, div_done, div_busy;
    logic [SPD_W-1:0]    div_quot;

    logic [DIST_W-1:0] cur    [CHANNELS];
    logic [DIST_W:0]   diff   [CHANNELS];
    logic [DIST_W-1:0] adelta [CHANNELS];
    logic [CHANNELS-1:0] closer;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cur[c]    = distance[c*DIST_W +: DIST_W];
            diff[c]   = {1'b0, cur[c]} - {1'b0, prev_q[c]};
            closer[c] = diff[c][DIST_W];
            adelta[c] = closer[c] ? DIST_W'(-diff[c]) : diff[c][DIST_W-1:0];
        end
    end

    // Lowest pending channel at or after rr_q, wrapping.
    always_comb begin : p_arb
        int unsigned c;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            c = 32'(rr_q) + i;
            if (c >= CHANNELS) c = c - CHANNELS;
            if (!gnt_any && pending_q[c]) begin
                gnt_any = 1'b1;
                gnt_idx = CH_W'(c);
            end
        end
    end

    assign div_start = gnt_any && !div_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                prev_q[c]   <= '0;
                jdelta_q[c] <= '0;
                jintv_q[c]  <= '0;
                intv_q[c]   <= '0;
            end
            primed_q   <= '0;
            pending_q  <= '0;
            jappr_q    <= '0;
            overrun_q  <= '0;
            rr_q       <= '0;
            grant_q    <= '0;
            gnt_appr_q <= 1'b0;
        end else begin
            overrun_q <= '0;
            if (div_start) begin
                grant_q    <= gnt_idx;
                gnt_appr_q <= jappr_q[gnt_idx];
                rr_q       <= (gnt_idx == CH_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
            end
            for (int c = 0; c < CHANNELS; c++) begin
                // Clear first so a sample in the grant cycle re-arms pending.
                if (div_start && gnt_idx == CH_W'(c)) pending_q[c] <= 1'b0;
                if (sample_valid[c]) begin
                    intv_q[c]   <= TIME_W'(1);
                    prev_q[c]   <= cur[c];
                    primed_q[c] <= 1'b1;
                    if (primed_q[c]) begin
                        jdelta_q[c]  <= adelta[c];
                        jappr_q[c]   <= closer[c];
                        jintv_q[c]   <= intv_q[c];
                        pending_q[c] <= 1'b1;
                        overrun_q[c] <= pending_q[c] && !(div_start && gnt_idx == CH_W'(c));
                    end
                end else if (intv_q[c] != '1) begin
                    intv_q[c] <= intv_q[c] + 1'b1;
                end
            end
        end
    end

    speed_div_seq #(
        .NUM_W  (NUM_W),
        .TIME_W (TIME_W),
        .SPD_W  (SPD_W)
    ) u_div (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (div_start),
        .numer_i (NUM_W'(jdelta_q[gnt_idx]) << SCALE_SHIFT),
        .denom_i (jintv_q[gnt_idx]),
        .done_o  (div_done),
        .busy_o  (div_busy),
        .quot_o  (div_quot)
    );

    logic             out_wr, out_appr;
    logic [CH_W-1:0]  out_ch;
    logic [SPD_W-1:0] out_val;

`ifdef SPEED_AVG_EN
    localparam int unsigned AVG_W = clog2(AVG_DEPTH);

    logic [SPD_W-1:0]       ring_q [CHANNELS][AVG_DEPTH];
    logic [AVG_W-1:0]       wp_q   [CHANNELS];
    logic                   st1_valid_q, st1_appr_q;
    logic [CH_W-1:0]        st1_ch_q;
    logic [SPD_W+AVG_W-1:0] ring_sum;

    always_comb begin
        ring_sum = '0;
        for (int i = 0; i < AVG_DEPTH; i++) begin
            ring_sum = ring_sum + (SPD_W+AVG_W)'(ring_q[st1_ch_q][i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wp_q[c] <= '0;
                for (int i = 0; i < AVG_DEPTH; i++) ring_q[c][i] <= '0;
            end
            st1_valid_q <= 1'b0;
            st1_appr_q  <= 1'b0;
            st1_ch_q    <= '0;
        end else begin
            st1_valid_q <= div_done;
            if (div_done) begin
                ring_q[grant_q][wp_q[grant_q]] <= div_quot;
                wp_q[grant_q] <= wp_q[grant_q] + 1'b1;
                st1_ch_q      <= grant_q;
                st1_appr_q    <= gnt_appr_q;
            end
        end
    end

    assign out_wr   = st1_valid_q;
    assign out_ch   = st1_ch_q;
    assign out_appr = st1_appr_q;
    assign out_val  = SPD_W'(ring_sum >> AVG_W);
`else
    assign out_wr   = div_done;
    assign out_ch   = grant_q;
    assign out_appr = gnt_appr_q;
    assign out_val  = div_quot;
`endif

    logic [SPD_W-1:0]    speed_q [CHANNELS];
    logic [CHANNELS-1:0] valid_q, appr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) speed_q[c] <= '0;
            valid_q <= '0;
            appr_q  <= '0;
        end else begin
            valid_q <= '0;
            if (out_wr) begin
                speed_q[out_ch] <= out_val;
                appr_q[out_ch]  <= out_appr;
                valid_q[out_ch] <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_flat
        assign speed[c*SPD_W +: SPD_W] = speed_q[c];
    end

    assign speed_valid = valid_q;
    assign approaching = appr_q;
    assign overrun     = overrun_q;
    assign busy        = div_busy;

endmodule
